// File: rtl/histogram_core_if.sv
// Stream, control and status bundle for histogram_core.
// The core takes the slave side; the producer/consumer drives the master side.
interface histogram_core_if #(
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned NUM_BINS = 16,
  parameter int unsigned COUNT_W  = 16
);
  localparam int unsigned BIN_W = $clog2(NUM_BINS);

  logic               in_valid;
  logic               in_ready;
  logic [DATA_W-1:0]  in_data;
  logic               clear_req;
  logic               dump_req;
  logic               out_valid;
  logic               out_ready;
  logic [BIN_W-1:0]   out_bin;
  logic [COUNT_W-1:0] out_count;
  logic               out_last;
  logic               busy;
  logic               overflow;

  modport master (
    output in_valid, in_data, clear_req, dump_req, out_ready,
    input  in_ready, out_valid, out_bin, out_count, out_last, busy, overflow
  );

  modport slave (
    input  in_valid, in_data, clear_req, dump_req, out_ready,
    output in_ready, out_valid, out_bin, out_count, out_last, busy, overflow
  );
endinterface

// File: rtl/histogram_core.sv
// Histogram engine: bins samples by their MSBs, with a one-bin-per-cycle clear sweep and a back-pressured dump.
// Build option HIST_SATURATE_EN: overflowing bins hold at max instead of wrapping to zero.
module histogram_core #(
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned NUM_BINS = 16,
  parameter int unsigned COUNT_W  = 16
) (
  input logic             clk,
  input logic             rst,
  histogram_core_if.slave bus
);
  localparam int unsigned        BIN_W     = $clog2(NUM_BINS);
  localparam logic [BIN_W-1:0]   LAST_BIN  = BIN_W'(NUM_BINS - 1);
  localparam logic [COUNT_W-1:0] COUNT_MAX = '1;

  typedef enum logic [1:0] {
    S_CLEAR,
    S_ACCUM,
    S_DUMP
  } state_t;

  state_t             r_state;
  logic [BIN_W-1:0]   r_idx;
  logic [BIN_W-1:0]   r_out_bin;
  logic               r_in_ready;
  logic               r_busy;
  logic               r_out_valid;
  logic               r_out_last;
  logic               r_overflow;
  logic [COUNT_W-1:0] r_bins [NUM_BINS];

  logic [BIN_W-1:0]   w_bin;
  logic [COUNT_W-1:0] w_cur;
  logic [COUNT_W-1:0] w_inc;
  logic               w_at_max;
  logic               w_accept;
  logic               w_unused_data;

  assign w_bin         = bus.in_data[DATA_W-1 -: BIN_W];
  assign w_unused_data = ^bus.in_data;
  assign w_cur         = r_bins[w_bin];
  assign w_at_max      = (w_cur == COUNT_MAX);
  assign w_accept      = (r_state == S_ACCUM) && bus.in_valid;

`ifdef HIST_SATURATE_EN
  assign w_inc = w_at_max ? COUNT_MAX : w_cur + COUNT_W'(1);
`else
  assign w_inc = w_cur + COUNT_W'(1);
`endif

  // Counter array kept free of reset so it can map onto a single-port RAM.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (r_state == S_CLEAR) begin
        r_bins[r_idx] <= '0;
      end else if (w_accept) begin
        r_bins[w_bin] <= w_inc;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_CLEAR;
      r_idx       <= '0;
      r_out_bin   <= '0;
      r_in_ready  <= 1'b0;
      r_busy      <= 1'b1;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
      r_overflow  <= 1'b0;
    end else begin
      case (r_state)
        S_CLEAR: begin
          if (r_idx == LAST_BIN) begin
            r_state    <= S_ACCUM;
            r_idx      <= '0;
            r_in_ready <= 1'b1;
            r_busy     <= 1'b0;
          end else begin
            r_idx <= r_idx + BIN_W'(1);
          end
        end
        S_ACCUM: begin
          if (bus.in_valid && w_at_max) begin
            r_overflow <= 1'b1;
          end
          // Clear takes priority; the sample above is still counted first.
          if (bus.clear_req) begin
            r_state    <= S_CLEAR;
            r_idx      <= '0;
            r_in_ready <= 1'b0;
            r_busy     <= 1'b1;
            r_overflow <= 1'b0;
          end else if (bus.dump_req) begin
            r_state     <= S_DUMP;
            r_out_bin   <= '0;
            r_out_valid <= 1'b1;
            r_out_last  <= (LAST_BIN == '0);
            r_in_ready  <= 1'b0;
            r_busy      <= 1'b1;
          end
        end
        S_DUMP: begin
          if (bus.out_ready) begin
            if (r_out_last) begin
              r_state     <= S_ACCUM;
              r_out_bin   <= '0;
              r_out_valid <= 1'b0;
              r_out_last  <= 1'b0;
              r_in_ready  <= 1'b1;
              r_busy      <= 1'b0;
            end else begin
              r_out_bin  <= r_out_bin + BIN_W'(1);
              r_out_last <= ((r_out_bin + BIN_W'(1)) == LAST_BIN);
            end
          end
        end
        default: begin
          r_state <= S_CLEAR;
          r_idx   <= '0;
        end
      endcase
    end
  end

  assign bus.in_ready  = r_in_ready;
  assign bus.busy      = r_busy;
  assign bus.out_valid = r_out_valid;
  assign bus.out_bin   = r_out_bin;
  assign bus.out_last  = r_out_last;
  assign bus.overflow  = r_overflow;
  assign bus.out_count = r_out_valid ? r_bins[r_out_bin] : '0;

endmodule

// File: tb/tb_histogram_core.sv
// Directed bench for histogram_core: sweep timing, binning, stalled dump, clear priority, overflow, reset mid-dump.
module tb_histogram_core;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  histogram_core_if #(.DATA_W(8), .NUM_BINS(16), .COUNT_W(16)) bus ();
  histogram_core_if #(.DATA_W(8), .NUM_BINS(16), .COUNT_W(4))  sbus ();

  histogram_core #(.DATA_W(8), .NUM_BINS(16), .COUNT_W(16)) u_dut (
    .clk(clk), .rst(rst), .bus(bus)
  );
  histogram_core #(.DATA_W(8), .NUM_BINS(16), .COUNT_W(4)) u_small (
    .clk(clk), .rst(rst), .bus(sbus)
  );

  typedef struct {
    int bin;
    int count;
    bit last;
  } word_t;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Sweep after the edge that released reset or took clear_req.
  task automatic sweep_check(input string tag);
    for (int k = 1; k <= 16; k++) begin
      tick();
      check({tag, " sweep in_ready"}, longint'(bus.in_ready), longint'(k == 16));
      check({tag, " sweep out_valid"}, longint'(bus.out_valid), 0);
    end
  endtask

  task automatic do_dump(input word_t exp[16], input bit stall, input string tag);
    int h = 0;
    int c = 0;
    bit p_stall = 1'b0;
    int p_bin = 0;
    int p_cnt = 0;
    bus.dump_req = 1'b1;
    tick();
    bus.dump_req = 1'b0;
    check({tag, " first valid"}, longint'(bus.out_valid), 1);
    while (h < 16 && c < 400) begin
      bus.out_ready = stall ? ((c % 4 == 0) || (c % 4 == 3)) : 1'b1;
      if (p_stall) begin
        check({tag, " hold bin"}, longint'(bus.out_bin), longint'(p_bin));
        check({tag, " hold count"}, longint'(bus.out_count), longint'(p_cnt));
      end
      if (bus.out_valid && bus.out_ready) begin
        check({tag, " bin"}, longint'(bus.out_bin), longint'(exp[h].bin));
        check({tag, " count"}, longint'(bus.out_count), longint'(exp[h].count));
        check({tag, " last"}, longint'(bus.out_last), longint'(exp[h].last));
        h++;
      end
      p_stall = bus.out_valid && !bus.out_ready;
      p_bin   = int'(bus.out_bin);
      p_cnt   = int'(bus.out_count);
      tick();
      c++;
    end
    bus.out_ready = 1'b1;
    check({tag, " handshakes"}, longint'(h), 16);
    check({tag, " back in accum"}, longint'(bus.in_ready), 1);
    check({tag, " valid dropped"}, longint'(bus.out_valid), 0);
    check({tag, " not busy"}, longint'(bus.busy), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    word_t zeros[16];
    word_t hist[16];
    logic [7:0] samples[5];
    int c;

    for (int i = 0; i < 16; i++) begin
      zeros[i] = '{bin: i, count: 0, last: (i == 15)};
      hist[i]  = '{bin: i, count: 0, last: (i == 15)};
    end
    hist[0].count  = 2;
    hist[1].count  = 1;
    hist[15].count = 2;
    samples = '{8'h00, 8'h0F, 8'h10, 8'hFF, 8'hF0};

    rst = 1'b1;
    bus.in_valid = 1'b0;  bus.in_data = '0;  bus.clear_req = 1'b0;
    bus.dump_req = 1'b0;  bus.out_ready = 1'b1;
    sbus.in_valid = 1'b0; sbus.in_data = '0; sbus.clear_req = 1'b0;
    sbus.dump_req = 1'b0; sbus.out_ready = 1'b1;
    tick();
    tick();
    check("rst in_ready", longint'(bus.in_ready), 0);
    check("rst out_valid", longint'(bus.out_valid), 0);
    check("rst out_bin", longint'(bus.out_bin), 0);
    check("rst out_count", longint'(bus.out_count), 0);
    check("rst out_last", longint'(bus.out_last), 0);
    check("rst busy", longint'(bus.busy), 1);
    check("rst overflow", longint'(bus.overflow), 0);

    rst = 1'b0;
    sweep_check("init");
    do_dump(zeros, 1'b0, "zero");

    for (int i = 0; i < 5; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = samples[i];
      check("sample in_ready", longint'(bus.in_ready), 1);
      tick();
    end
    bus.in_valid = 1'b0;
    do_dump(hist, 1'b0, "samp");
    check("samp overflow", longint'(bus.overflow), 0);
    do_dump(hist, 1'b1, "stall");

    bus.in_valid  = 1'b1;
    bus.in_data   = 8'h20;
    bus.clear_req = 1'b1;
    bus.dump_req  = 1'b1;
    tick();
    bus.in_valid  = 1'b0;
    bus.clear_req = 1'b0;
    bus.dump_req  = 1'b0;
    check("clr busy", longint'(bus.busy), 1);
    check("clr in_ready", longint'(bus.in_ready), 0);
    check("clr no dump", longint'(bus.out_valid), 0);
    sweep_check("clr");
    do_dump(zeros, 1'b0, "clr");

    sbus.in_valid = 1'b1;
    sbus.in_data  = 8'h30;
    repeat (17) tick();
    sbus.in_valid = 1'b0;
    check("small overflow", longint'(sbus.overflow), 1);
    sbus.dump_req = 1'b1;
    tick();
    sbus.dump_req = 1'b0;
    c = 0;
    while (!(sbus.out_valid && sbus.out_bin == 4'd3) && c < 40) begin
      tick();
      c++;
    end
`ifdef HIST_SATURATE_EN
    check("small bin3", longint'(sbus.out_count), 15);
`else
    check("small bin3", longint'(sbus.out_count), 1);
`endif
    c = 0;
    while (sbus.out_valid && c < 40) begin
      tick();
      c++;
    end
    check("small dump end", longint'(sbus.out_valid), 0);

    bus.dump_req = 1'b1;
    tick();
    bus.dump_req = 1'b0;
    c = 0;
    while (bus.out_bin != 4'd5 && c < 40) begin
      tick();
      c++;
    end
    check("mid reached word5", longint'(bus.out_bin), 5);
    rst = 1'b1;
    tick();
    check("mid rst out_valid", longint'(bus.out_valid), 0);
    check("mid rst busy", longint'(bus.busy), 1);
    check("mid rst in_ready", longint'(bus.in_ready), 0);
    check("mid rst out_bin", longint'(bus.out_bin), 0);
    rst = 1'b0;
    sweep_check("mid");
    do_dump(zeros, 1'b0, "mid");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/histogram_core.md
# histogram_core

Parametrised histogram engine: accepts a stream of unsigned samples, bins each by its most-significant bits into `NUM_BINS` counters, and streams the full histogram out on request. It is the reusable core behind the top-level histogramming tile and generalises the earlier fixed design with configurable sample width, bin count and counter width. It also adds a RAM-friendly clear sweep, a back-pressured dump port and overflow tracking.

## Interface
- `DATA_W`, 8: sample width in bits.
- `NUM_BINS`, 16: bin count; power of two, 2..2^DATA_W. Local `BIN_W = $clog2(NUM_BINS)`.
- `COUNT_W`, 16: per-bin counter width, ≥2.

- `clk`  in  1  single clock, all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  sample present.
- `in_ready`  out  1  core can accept a sample.
- `in_data`  in  DATA_W  sample value.
- `clear_req`  in  1  single-cycle pulse: zero all bins.
- `dump_req`  in  1  single-cycle pulse: stream histogram out.
- `out_valid`  out  1  dump word present.
- `out_ready`  in  1  consumer accepts dump word.
- `out_bin`  out  BIN_W  bin index of current dump word.
- `out_count`  out  COUNT_W  count of `out_bin`.
- `out_last`  out  1  current dump word is bin NUM_BINS-1.
- `busy`  out  1  state is CLEAR or DUMP.
- `overflow`  out  1  sticky: some bin exceeded 2^COUNT_W-1 since last clear.

## Operation
- Bin index = `in_data[DATA_W-1 -: BIN_W]`.
- States: CLEAR, ACCUM, DUMP. Reset → CLEAR with sweep index 0.
- CLEAR: one bin zeroed per cycle, index 0..NUM_BINS-1. `overflow` cleared on entry. After bin NUM_BINS-1 is zeroed → ACCUM. `in_ready`=0, `busy`=1.
- ACCUM: `in_ready`=1, `busy`=0.
  - `in_valid`=1 → bin incremented at that edge.
  - `clear_req` → CLEAR.
  - `dump_req` → DUMP with dump index 0.
  - `clear_req` and `dump_req` together → CLEAR wins.
  - A sample accepted in the same cycle as either request is still counted before the request takes effect.
- DUMP: `in_ready`=0, `out_valid`=1, `out_bin`=dump index, `out_count`=bin content, `out_last`=(index==NUM_BINS-1).
  - Index advances only on `out_valid && out_ready`. `out_*` hold stable while `out_ready`=0.
  - Handshake with `out_last`=1 → ACCUM. Counts are preserved, so accumulation resumes.
- `clear_req`/`dump_req` outside ACCUM are ignored. No queuing.
- Increment at 2^COUNT_W-1 sets `overflow`. Resulting count per Configuration.
- `in_data` is ignored when `in_ready`=0.

## Timing
- Reset values:
  - `in_ready`=0, `out_valid`=0, `out_bin`=0, `out_count`=0, `out_last`=0, `busy`=1, `overflow`=0.
  - Counter contents are undefined until the sweep completes.
- Reset deasserted at edge 0 → bins 0..NUM_BINS-1 zeroed on edges 1..NUM_BINS. `in_ready`=1 from the cycle after edge NUM_BINS. Same sweep length after `clear_req`.
- Sample accepted at edge N → count visible (dump) from cycle after edge N. Back-to-back samples to the same bin each count (no RMW hazard).
- `dump_req` at edge N → `out_valid`=1 in the cycle after edge N. Full dump is at least NUM_BINS cycles with `out_ready` held 1.
- `rst` asserted mid-CLEAR/DUMP → immediate return to reset state. Dump aborts with `out_valid`=0 next cycle, and a new sweep starts.
- All outputs registered or decoded directly from state/index registers. No input→output combinational path except `out_count` from the counter array.

## Configuration
- `HIST_SATURATE_EN` defined: an overflowing bin holds at 2^COUNT_W-1.
- `HIST_SATURATE_EN` undefined: an overflowing bin wraps to 0.
- `overflow` sets identically in both builds.

## Test plan
- Reset, 16-cycle sweep, then dump with `out_ready`=1: `in_ready` rises exactly after edge 16. Dump gives 16 words, bins 0..15, all counts 0, `out_last` only on bin 15.
- Samples 0x00, 0x0F, 0x10, 0xFF, 0xF0 back-to-back, then dump: bin0=2, bin1=1, bin15=2, others 0. `overflow`=0.
- Dump with `out_ready` toggling 1,0,0,1: `out_bin` and `out_count` hold during stalls. Exactly 16 handshakes occur, and the core returns to ACCUM with counts intact.
- `clear_req`+`dump_req` same cycle with sample 0x20 accepted: CLEAR runs 16 cycles, no `out_valid`. Subsequent dump shows all zeros.
- COUNT_W=4, 17 samples of 0x30:
  - `overflow`=1 in both builds.
  - With `HIST_SATURATE_EN`: bin3=15.
  - Without: bin3=1.
- Assert `rst` at dump word 5: `out_valid`=0 next cycle, `busy`=1, fresh 16-cycle sweep, then zeros on dump.
